// File: rtl/mult_div_pkg.sv
// Shared types and helpers for the multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_div_pkg;

  // Width of the carry-lookahead adder used for the trial subtraction.
  localparam int CLA_W = 32;

  // Sequencing states of the iterative divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Iteration-count width for a datapath of the given width.
  function automatic int div_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/cla_32.sv
// 32-bit adder: o_sum = i_a + i_b + i_cin, with carry out.
// Latency: combinational.
// Backpressure: none.
// Ports: i_a, i_b (addends), i_cin (carry in), o_sum (sum), o_cout (carry out).
module cla_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Generate/propagate carry recurrence; synthesis flattens this into a
  // lookahead structure.
  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < 32; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign o_sum  = w_p ^ w_c[31:0];
  assign o_cout = w_c[32];

endmodule

// File: rtl/mult_div_seq_divider.sv
// Sequential signed restoring divider, one quotient bit per cycle.
// Latency: result strobe WIDTH+2 cycles after start (1 cycle for divide-by-zero).
// Backpressure: none; a new ctrl_DIV at any time discards the operation in flight.
// Ports: clock, reset (sync, active-high), data_operandA/B (dividend/divisor),
//   ctrl_DIV (start), data_result (quotient), data_exception (div-by-zero),
//   data_resultRDY (1-cycle valid strobe).
// Option: DIV_REMAINDER_EN adds data_remainder (sign follows the dividend).
// WIDTH must not exceed 32 (trial subtraction uses the 32-bit cla_32).
module mult_div_seq_divider
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int             CNT_W = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  div_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [WIDTH-1:0] r_quo;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_div;      // |B|
  logic             r_q_neg;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_rem_shift;
  logic [CLA_W-1:0] w_add_a;
  logic [CLA_W-1:0] w_add_b;
  logic [CLA_W-1:0] w_add_sum;
  logic             w_ge;

  // Magnitudes are treated as unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  assign w_abs_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_abs_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign w_b_zero = (data_operandB == '0);

  // The partial remainder is always below |B| <= 2^(WIDTH-1), so after the
  // shift it still fits in WIDTH unsigned bits.
  assign w_rem_shift = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};

  // Zero-extend into the adder; inverted divisor with carry-in 1 subtracts,
  // and carry-out set means the difference is non-negative.
  always_comb begin
    w_add_a              = '0;
    w_add_a[WIDTH-1:0]   = w_rem_shift;
    w_add_b              = '0;
    w_add_b[WIDTH-1:0]   = r_div;
    w_add_b              = ~w_add_b;
  end

  cla_32 u_cla (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (1'b1),
    .o_sum  (w_add_sum),
    .o_cout (w_ge)
  );

`ifdef DIV_REMAINDER_EN
  logic             r_r_neg;
  logic [WIDTH-1:0] r_remainder;
  assign data_remainder = r_remainder;
`endif

  // Next-state and strobe decode.
  always_comb begin
    w_next         = r_state;
    data_resultRDY = 1'b0;
    if (ctrl_DIV) begin
      w_next = w_b_zero ? DONE : RUN;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        RUN:     w_next = (r_cnt == LAST) ? FIX : RUN;
        FIX:     w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
    if (r_state == DONE) data_resultRDY = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
      r_remainder <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (ctrl_DIV) begin
        r_cnt   <= '0;
        r_rem   <= '0;
        r_quo   <= w_abs_a;
        r_div   <= w_abs_b;
        r_q_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`ifdef DIV_REMAINDER_EN
        r_r_neg <= data_operandA[WIDTH-1];
`endif
        if (w_b_zero) begin
          r_result    <= '0;
          r_exception <= 1'b1;
`ifdef DIV_REMAINDER_EN
          r_remainder <= '0;
`endif
        end else begin
          r_exception <= 1'b0;
        end
      end else begin
        case (r_state)
          RUN: begin
            r_rem <= w_ge ? w_add_sum[WIDTH-1:0] : w_rem_shift;
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
          end
          FIX: begin
            r_result <= r_q_neg ? -r_quo : r_quo;
`ifdef DIV_REMAINDER_EN
            r_remainder <= r_r_neg ? -r_rem : r_rem;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;

endmodule

// File: tb/tb_mult_div_seq_divider.sv
// Directed self-checking bench for mult_div_seq_divider (WIDTH=32).
// Latency: n/a.
// Backpressure: n/a.
module tb_mult_div_seq_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mult_div_seq_divider #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present operands with ctrl_DIV for one rising edge; returns just after it.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV      = 1'b0;
  endtask

  // Count cycles from the sampling edge until the strobe is seen.
  task automatic wait_rdy(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!data_resultRDY && lat < 100);
  endtask

  task automatic check_done(input string tag, input int lat, input int exp_lat,
                            input logic [31:0] exp_q, input logic exp_exc,
                            input logic [31:0] exp_r);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdy"}, 32'(data_resultRDY), 32'd1);
    chk({tag, "_q"},   data_result, exp_q);
    chk({tag, "_exc"}, 32'(data_exception), 32'(exp_exc));
`ifdef DIV_REMAINDER_EN
    chk({tag, "_rem"}, data_remainder, exp_r);
`else
    if (exp_r != exp_r) $display("unreachable");
`endif
    @(negedge clock);
    chk({tag, "_rdy_1cyc"}, 32'(data_resultRDY), 32'd0);
    chk({tag, "_hold"},     data_result, exp_q);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_q,
                        input logic exp_exc, input logic [31:0] exp_r);
    int lat;
    start(a, b);
    wait_rdy(lat);
    check_done(tag, lat, exp_lat, exp_q, exp_exc, exp_r);
  endtask

  initial begin
    int lat;
    int seen;
    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_q",   data_result, 32'd0);
    chk("rst_exc", 32'(data_exception), 32'd0);
    chk("rst_rdy", 32'(data_resultRDY), 32'd0);
    reset = 1'b0;

    run_op("p100_7",  32'd100,            32'd7,          34, 32'd14,         1'b0, 32'd2);
    run_op("n100_7",  -32'sd100,          32'd7,          34, 32'hFFFFFFF2,   1'b0, 32'hFFFFFFFE);
    run_op("p100_n7", 32'd100,            -32'sd7,        34, 32'hFFFFFFF2,   1'b0, 32'd2);
    run_op("div0",    32'd5,              32'd0,          1,  32'd0,          1'b1, 32'd0);

    // Exception must drop as soon as a non-zero divisor is accepted.
    start(32'd9, 32'd3);
    @(negedge clock);
    chk("exc_clr", 32'(data_exception), 32'd0);
    wait_rdy(lat);
    check_done("p9_3", lat + 1, 34, 32'd3, 1'b0, 32'd0);

    run_op("min_n1",  32'h80000000,       32'hFFFFFFFF,   34, 32'h80000000,   1'b0, 32'd0);
    run_op("n1_p1",   32'hFFFFFFFF,       32'd1,          34, 32'hFFFFFFFF,   1'b0, 32'd0);
    run_op("n7_2",    -32'sd7,            32'd2,          34, 32'hFFFFFFFD,   1'b0, 32'hFFFFFFFF);

    // Restart: a second ctrl_DIV ten cycles in replaces the first operation.
    start(32'd100, 32'd7);
    repeat (9) @(posedge clock);
    start(32'd50, 32'd5);
    wait_rdy(lat);
    check_done("restart", lat, 34, 32'd10, 1'b0, 32'd0);

    // Reset mid-operation: outputs clear and no strobe appears.
    start(32'd100, 32'd7);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_q",   data_result, 32'd0);
    chk("abort_exc", 32'(data_exception), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    chk("abort_no_rdy", 32'(seen), 32'd0);
    run_op("after_rst", 32'd100, 32'd7, 34, 32'd14, 1'b0, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
